// File: rtl/uarch_pkg.sv
// -----------------------------------------------------------------------------
// uarch_pkg
// Shared micro-architecture definitions for the out-of-order core back end:
// the writeback packet carried from functional units to the common data bus,
// default FU / CDB sizing, and the functional-unit index map.
// -----------------------------------------------------------------------------
package uarch_pkg;

   localparam int unsigned NUM_FU    = 4;  // writeback requesters
   localparam int unsigned CDB_PORTS = 2;  // broadcast slots per cycle
   localparam int unsigned PREG_W    = 6;  // physical register tag width
   localparam int unsigned XLEN      = 32; // result data width

   // Functional-unit index map (position in the fu_result / fu_cdb_gnt vectors).
   typedef enum logic [1:0] {
      FU_ALU0 = 2'd0,
      FU_ALU1 = 2'd1,
      FU_LSU  = 2'd2,
      FU_MUL  = 2'd3
   } fu_idx_e;

   // Writeback packet; is_valid doubles as the CDB request from the FU.
   typedef struct packed {
      logic              is_valid;
      logic [PREG_W-1:0] dest_reg;
      logic [XLEN-1:0]   result;
   } writeback_packet_t;

   // Width of a pointer that can index n entries (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational rotating scan. Starting at i_ptr and wrapping from NUM_REQ-1
// to 0, it assigns up to NUM_SLOTS requesters to output slots in scan order:
// the first requester found goes to slot 0, the next to slot 1, and so on.
//
// Ports
//   i_req  [NUM_REQ]            request vector
//   i_ptr  [PTR_W]              scan start position (0..NUM_REQ-1)
//   o_gnt  [NUM_SLOTS][NUM_REQ] grant matrix, each row one-hot or all-zero
// -----------------------------------------------------------------------------
module rr_picker
   import uarch_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned NUM_SLOTS = 2
) (
   input  logic [NUM_REQ-1:0]                 i_req,
   input  logic [ptr_width(NUM_REQ)-1:0]      i_ptr,
   output logic [NUM_SLOTS-1:0][NUM_REQ-1:0]  o_gnt
);

   always_comb begin
      int unsigned idx;
      int unsigned slot;
      // NOTE: every output and temporary gets a value before any conditional
      // logic, so no path leaves them unassigned and no latch is inferred.
      o_gnt = '0;
      slot  = 0;
      idx   = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         // Rotated index without a modulo operator: i_ptr < NUM_REQ, so a
         // single subtraction is enough to wrap.
         idx = 32'(i_ptr) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (i_req[idx] && (slot < NUM_SLOTS)) begin
            o_gnt[slot][idx] = 1'b1;
            slot = slot + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus writeback arbiter. Each cycle it grants up to CDB_PORTS of
// the NUM_FU requesting functional units in rotating order and registers the
// granted packets onto the CDB, where they are visible for exactly one cycle.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   flush       in   pipeline flush; suppresses this cycle's grants
//   fu_result   in   [NUM_FU] writeback packets, is_valid = request
//   fu_cdb_gnt  out  [NUM_FU] combinational grant (packet accepted this cycle)
//   cdb         out  [CDB_PORTS] registered broadcast slots
// -----------------------------------------------------------------------------
module cdb_arbiter
   import uarch_pkg::*;
#(
   parameter int unsigned NUM_FU    = uarch_pkg::NUM_FU,
   parameter int unsigned CDB_PORTS = uarch_pkg::CDB_PORTS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  writeback_packet_t [NUM_FU-1:0]      fu_result,
   output logic              [NUM_FU-1:0]      fu_cdb_gnt,
   output writeback_packet_t [CDB_PORTS-1:0]   cdb
);

   localparam int unsigned PTR_W = ptr_width(NUM_FU);

   logic              [PTR_W-1:0]                r_rr_ptr;
   logic              [PTR_W-1:0]                w_rr_ptr_nxt;
   writeback_packet_t [CDB_PORTS-1:0]            r_cdb;
   writeback_packet_t [CDB_PORTS-1:0]            w_cdb_nxt;
   logic              [NUM_FU-1:0]               w_req;
   logic              [CDB_PORTS-1:0][NUM_FU-1:0] w_gnt_mat;

   // Flush and reset both mask the requests before the scan, so neither can
   // produce a grant, a CDB load or a pointer move.
   always_comb begin
      w_req = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         w_req[i] = fu_result[i].is_valid & ~flush & rst;
      end
   end

   rr_picker #(
      .NUM_REQ   (NUM_FU),
      .NUM_SLOTS (CDB_PORTS)
   ) u_rr_picker (
      .i_req (w_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt_mat)
   );

   // Slots are filled in scan order, so the last slot with a grant holds the
   // last-granted FU; later iterations overwrite the pointer update.
   always_comb begin
      fu_cdb_gnt   = '0;
      w_cdb_nxt    = '0;
      w_rr_ptr_nxt = r_rr_ptr;
      for (int unsigned s = 0; s < CDB_PORTS; s++) begin
         fu_cdb_gnt = fu_cdb_gnt | w_gnt_mat[s];
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (w_gnt_mat[s][i]) begin
               w_cdb_nxt[s] = fu_result[i];
               w_rr_ptr_nxt = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
            end
         end
      end
   end

   // The CDB reloads every cycle (empty slots load all-zero), so a broadcast
   // lives for exactly one cycle without any explicit clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the CDB slot registers are reset, unlike a data array, because
         // consumers act on is_valid directly and a stale packet after reset
         // would be written back into the machine.
         r_cdb    <= '0;
         r_rr_ptr <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values computed by the combinational blocks.
         r_cdb    <= w_cdb_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   assign cdb = r_cdb;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A reference model kept here builds the
// rotated list of requesters with a queue, keeps the first CDB_PORTS of them,
// and predicts grants, next-cycle CDB contents and the rotating pointer.
// Directed scenarios additionally compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   import uarch_pkg::*;

   localparam int unsigned N = NUM_FU;
   localparam int unsigned P = CDB_PORTS;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         flush;
   writeback_packet_t [N-1:0]    fu_result;
   logic              [N-1:0]    fu_cdb_gnt;
   writeback_packet_t [P-1:0]    cdb;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned m_ptr    = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_FU    (N),
      .CDB_PORTS (P)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fu_result  (fu_result),
      .fu_cdb_gnt (fu_cdb_gnt),
      .cdb        (cdb)
   );

   function automatic writeback_packet_t mk_pkt(input logic [PREG_W-1:0] d,
                                                input logic [XLEN-1:0]   r);
      writeback_packet_t p;
      p.is_valid = 1'b1;
      p.dest_reg = d;
      p.result   = r;
      return p;
   endfunction

   // Random payload on every FU; non-requesting FUs carry garbage fields with
   // is_valid 0 so that leaking them onto the CDB would be visible.
   task automatic set_req(input logic [N-1:0] v);
      for (int unsigned i = 0; i < N; i++) begin
         fu_result[i].is_valid = v[i];
         fu_result[i].dest_reg = PREG_W'($urandom);
         fu_result[i].result   = XLEN'($urandom);
      end
   endtask

   task automatic get_ptr(output logic [31:0] p);
      p = 32'(dut.r_rr_ptr);
   endtask

   // One clock cycle: inputs already driven just after a rising edge. Checks
   // the combinational grant mid-cycle, then the registered CDB and the
   // pointer just after the next edge. Returns the observed grant.
   task automatic run_cycle(output logic [N-1:0] g_obs);
      int unsigned       q[$];
      logic [N-1:0]      exp_gnt;
      writeback_packet_t exp_slot [P];
      logic [31:0]       ptr_obs;
      #4;
      exp_gnt = '0;
      if (rst && !flush) begin
         for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (m_ptr + k) % N;
            if (fu_result[idx].is_valid) q.push_back(idx);
         end
      end
      while (q.size() > P) void'(q.pop_back());
      foreach (q[k]) exp_gnt[q[k]] = 1'b1;
      g_obs = fu_cdb_gnt;
      n_checks++;
      if (fu_cdb_gnt !== exp_gnt) begin
         n_fail++;
         $display("FAIL model_gnt t=%0t: got %b expected %b", $time, fu_cdb_gnt, exp_gnt);
      end
      for (int unsigned s = 0; s < P; s++) begin
         exp_slot[s] = (s < q.size()) ? fu_result[q[s]] : '0;
      end
      if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % N;
      @(posedge clk);
      #1;
      for (int unsigned s = 0; s < P; s++) begin
         n_checks++;
         if (cdb[s] !== exp_slot[s]) begin
            n_fail++;
            $display("FAIL model_cdb[%0d] t=%0t: got %h expected %h", s, $time, cdb[s], exp_slot[s]);
         end
      end
      get_ptr(ptr_obs);
      n_checks++;
      if (ptr_obs !== m_ptr) begin
         n_fail++;
         $display("FAIL model_rr_ptr t=%0t: got %0d expected %0d", $time, ptr_obs, m_ptr);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      flush = 1'b0;
      set_req('0);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      m_ptr = 0;
   endtask

   task automatic test_reset();
      logic [N-1:0] g;
      logic [31:0]  p;
      rst   = 1'b0;
      flush = 1'b0;
      set_req('1);
      @(posedge clk);
      #1;
      n_checks++;
      if (cdb !== '0) begin
         n_fail++;
         $display("FAIL reset_cdb: got %h expected 0", cdb);
      end
      n_checks++;
      if (fu_cdb_gnt !== '0) begin
         n_fail++;
         $display("FAIL reset_gnt: got %b expected 0", fu_cdb_gnt);
      end
      get_ptr(p);
      n_checks++;
      if (p !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rr_ptr: got %0d expected 0", p);
      end
      set_req('0);
      rst   = 1'b1;
      m_ptr = 0;
      for (int c = 0; c < 10; c++) begin
         run_cycle(g);
         n_checks++;
         if (g !== 4'b0000 || cdb[0].is_valid !== 1'b0 || cdb[1].is_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset c=%0d: got gnt %b valids %b%b expected 0000 00",
                     c, g, cdb[1].is_valid, cdb[0].is_valid);
         end
      end
   endtask

   task automatic test_single_alu0();
      logic [N-1:0]      g;
      writeback_packet_t e;
      set_req('0);
      fu_result[FU_ALU0] = mk_pkt(6'd5, 32'h0000_00AA);
      e = mk_pkt(6'd5, 32'h0000_00AA);
      run_cycle(g);
      n_checks++;
      if (g !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_gnt: got %b expected 0001", g);
      end
      n_checks++;
      if (cdb[0] !== e || cdb[1] !== '0) begin
         n_fail++;
         $display("FAIL single_cdb: got %h %h expected %h 0", cdb[0], cdb[1], e);
      end
      set_req('0);
   endtask

   task automatic test_all_valid();
      logic [N-1:0] g;
      logic [31:0]  p;
      logic [N-1:0] exp_g [4];
      int unsigned  exp_p [4];
      exp_g = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
      exp_p = '{2, 0, 2, 0};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_req('1);
         run_cycle(g);
         get_ptr(p);
         n_checks++;
         if (g !== exp_g[c] || p !== exp_p[c]) begin
            n_fail++;
            $display("FAIL all_valid c=%0d: got gnt %b ptr %0d expected %b %0d",
                     c, g, p, exp_g[c], exp_p[c]);
         end
      end
      set_req('0);
   endtask

   task automatic test_wrap();
      logic [N-1:0]      g;
      logic [31:0]       p;
      writeback_packet_t p3;
      writeback_packet_t p0;
      do_reset();
      set_req(4'b0100);
      run_cycle(g);
      get_ptr(p);
      n_checks++;
      if (p !== 32'd3) begin
         n_fail++;
         $display("FAIL wrap_setup_ptr: got %0d expected 3", p);
      end
      set_req(4'b1001);
      p3 = fu_result[FU_MUL];
      p0 = fu_result[FU_ALU0];
      run_cycle(g);
      n_checks++;
      if (g !== 4'b1001) begin
         n_fail++;
         $display("FAIL wrap_gnt: got %b expected 1001", g);
      end
      n_checks++;
      if (cdb[0] !== p3 || cdb[1] !== p0) begin
         n_fail++;
         $display("FAIL wrap_order: got %h %h expected %h %h", cdb[0], cdb[1], p3, p0);
      end
      get_ptr(p);
      n_checks++;
      if (p !== 32'd1) begin
         n_fail++;
         $display("FAIL wrap_ptr: got %0d expected 1", p);
      end
      set_req('0);
   endtask

   task automatic test_flush();
      logic [N-1:0]      g;
      logic [31:0]       p;
      writeback_packet_t p1;
      flush = 1'b0;
      set_req(4'b0010);
      p1 = fu_result[FU_ALU1];
      run_cycle(g);
      n_checks++;
      if (g !== 4'b0010) begin
         n_fail++;
         $display("FAIL flush_pre_gnt: got %b expected 0010", g);
      end
      flush = 1'b1;
      set_req(4'b1101);
      n_checks++;
      if (cdb[0] !== p1) begin
         n_fail++;
         $display("FAIL flush_prior_broadcast: got %h expected %h", cdb[0], p1);
      end
      run_cycle(g);
      n_checks++;
      if (g !== 4'b0000) begin
         n_fail++;
         $display("FAIL flush_gnt: got %b expected 0000", g);
      end
      n_checks++;
      if (cdb[0].is_valid !== 1'b0 || cdb[1].is_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cdb: got valids %b%b expected 00", cdb[1].is_valid, cdb[0].is_valid);
      end
      get_ptr(p);
      n_checks++;
      if (p !== 32'd2) begin
         n_fail++;
         $display("FAIL flush_ptr_hold: got %0d expected 2", p);
      end
      flush = 1'b0;
      set_req('0);
   endtask

   task automatic test_async_reset();
      logic [N-1:0] g;
      logic [31:0]  p;
      set_req(4'b0001);
      run_cycle(g);
      n_checks++;
      if (cdb[0].is_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_setup: got valid %b expected 1", cdb[0].is_valid);
      end
      set_req('1);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (cdb !== '0) begin
         n_fail++;
         $display("FAIL areset_async_clear: got %h expected 0", cdb);
      end
      n_checks++;
      if (fu_cdb_gnt !== '0) begin
         n_fail++;
         $display("FAIL areset_gnt: got %b expected 0", fu_cdb_gnt);
      end
      @(posedge clk);
      #3;
      set_req('0);
      rst   = 1'b1;
      m_ptr = 0;
      get_ptr(p);
      n_checks++;
      if (p !== 32'd0 || cdb !== '0) begin
         n_fail++;
         $display("FAIL areset_release: got ptr %0d cdb %h expected 0 0", p, cdb);
      end
      run_cycle(g);
      n_checks++;
      if (cdb[0].is_valid !== 1'b0 || cdb[1].is_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_stale: got valids %b%b expected 00", cdb[1].is_valid, cdb[0].is_valid);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      for (int c = 0; c < 300; c++) begin
         flush = ($urandom_range(0, 7) == 0);
         set_req(N'($urandom));
         run_cycle(g);
      end
      flush = 1'b0;
      set_req('0);
   endtask

   // MUL requests every cycle against random competition; it must never go
   // ceil(N/P) consecutive cycles without a grant.
   task automatic test_fairness();
      logic [N-1:0] g;
      int           wait_cnt;
      int           bound;
      bound    = (N + P - 1) / P;
      wait_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         set_req(N'($urandom) | 4'b1000);
         run_cycle(g);
         wait_cnt = g[FU_MUL] ? 0 : wait_cnt + 1;
         n_checks++;
         if (wait_cnt >= bound) begin
            n_fail++;
            $display("FAIL fairness c=%0d: got wait %0d expected below %0d", c, wait_cnt, bound);
         end
      end
      set_req('0);
   endtask

   initial begin
      rst   = 1'b0;
      flush = 1'b0;
      fu_result = '0;
      test_reset();
      test_single_alu0();
      test_all_valid();
      test_wrap();
      test_flush();
      test_async_reset();
      test_random();
      test_fairness();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
